// File: rtl/gen_osc_poly.sv
// gen_osc_poly: multi-voice phase-accumulator oscillator with mixed output.
// A divider derives the sample strobe from the system clock. On each strobe
// the per-voice controls are snapshotted. Every voice then passes through one
// shared datapath: issue/accumulate, waveform (saw/square/triangle/sine ROM),
// then mix. The signed average of all voices is emitted once per frame.
// Ports:
//   i_clk48    system clock
//   i_rst48_n  synchronous active-low reset
//   i_pause    hold all accumulators (frames still produced)
//   i_voice_en per-voice enable
//   i_sync     per-voice phase-reset request (sticky until next strobe)
//   i_targetf  per-voice target frequency in Hz, 24 bits per voice
//   i_wave     per-voice waveform: 0 saw, 1 square, 2 triangle, 3 sine
//   o_sample   mixed signed sample
//   o_pulse    one-cycle strobe marking a new o_sample
module gen_osc_poly #(
  parameter int unsigned VOICES  = 4,
  parameter int unsigned CLK_HZ  = 48000000,
  parameter int unsigned FS_HZ   = 48000,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned SINE_AW = 8
) (
  input  logic                 i_clk48,
  input  logic                 i_rst48_n,
  input  logic                 i_pause,
  input  logic [VOICES-1:0]    i_voice_en,
  input  logic [VOICES-1:0]    i_sync,
  input  logic [VOICES*24-1:0] i_targetf,
  input  logic [VOICES*2-1:0]  i_wave,
  output logic [OUT_W-1:0]     o_sample,
  output logic                 o_pulse
);

  localparam int unsigned DIV   = CLK_HZ / FS_HZ;
  localparam int unsigned DIV_W = $clog2(DIV);
  localparam int unsigned VW    = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int unsigned LOG_V = $clog2(VOICES);
  localparam int unsigned SUM_W = OUT_W + LOG_V;
  localparam int unsigned ROM_N = 1 << SINE_AW;
  localparam longint unsigned STEP_MUL =
      ((64'd1 << (ACC_W + 10)) + 64'(FS_HZ / 2)) / 64'(FS_HZ);
  localparam logic [23:0]      F_MAX = 24'(FS_HZ / 2);
  localparam logic [OUT_W-1:0] HALF  = {1'b1, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StOut} state_e;

  // Quarter-wave magnitude, evaluated at elaboration only (Taylor series).
  function automatic logic [OUT_W-2:0] sine_mag(input int unsigned idx);
    real x, term, acc;
    x    = 3.14159265358979323846 / 2.0 * (real'(idx) + 0.5) / real'(ROM_N);
    term = x;
    acc  = x;
    for (int k = 1; k < 10; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      acc  = acc + term;
    end
    return (OUT_W - 1)'($rtoi(acc * real'((1 << (OUT_W - 1)) - 1) + 0.5));
  endfunction

  logic [OUT_W-2:0] rom [ROM_N];
  for (genvar gi = 0; gi < ROM_N; gi++) begin : g_rom
    localparam logic [OUT_W-2:0] Mag = sine_mag(gi);
    assign rom[gi] = Mag;
  end

  // Divider and frame strobe
  logic [DIV_W-1:0] div_q;
  logic             strobe;
  assign strobe = (div_q == DIV_W'(DIV - 1));

  always_ff @(posedge i_clk48) begin
    if (!i_rst48_n) div_q <= '0;
    else            div_q <= strobe ? '0 : div_q + DIV_W'(1);
  end

  // Sticky sync requests and per-frame snapshot
  logic [VOICES-1:0] sync_pend_q, f_sync_q, f_en_q;
  logic [23:0]       f_targ_q [VOICES];
  logic [1:0]        f_wave_q [VOICES];
  logic              f_pause_q;

  always_ff @(posedge i_clk48) begin
    if (!i_rst48_n) begin
      sync_pend_q <= '0;
      f_sync_q    <= '0;
      f_en_q      <= '0;
      f_pause_q   <= 1'b0;
      f_targ_q    <= '{default: '0};
      f_wave_q    <= '{default: '0};
    end else if (strobe) begin
      // A request landing on the strobe cycle itself joins this frame.
      f_sync_q    <= sync_pend_q | i_sync;
      sync_pend_q <= '0;
      f_en_q      <= i_voice_en;
      f_pause_q   <= i_pause;
      for (int v = 0; v < VOICES; v++) begin
        f_targ_q[v] <= i_targetf[24*v +: 24];
        f_wave_q[v] <= i_wave[2*v +: 2];
      end
    end else begin
      sync_pend_q <= sync_pend_q | i_sync;
    end
  end

  // Issue stage: step, pre-increment phase and accumulator update
  state_e            state_q;
  logic [VW-1:0]     vidx_q;
  logic              drain_q;
  logic [ACC_W-1:0]  acc_q [VOICES];
  logic [ACC_W-1:0]  acc_d, step;
  logic [23:0]       f_clamp;
  logic [OUT_W-1:0]  cur_p;

  always_comb begin
    f_clamp = (f_targ_q[vidx_q] > F_MAX) ? F_MAX : f_targ_q[vidx_q];
    step    = ACC_W'((64'(f_clamp) * STEP_MUL) >> 10);
    cur_p   = f_sync_q[vidx_q] ? '0 : acc_q[vidx_q][ACC_W-1 -: OUT_W];
    if (f_sync_q[vidx_q])                     acc_d = '0;
    else if (f_pause_q || !f_en_q[vidx_q])    acc_d = acc_q[vidx_q];
    else                                      acc_d = acc_q[vidx_q] + step;
  end

  always_ff @(posedge i_clk48) begin
    if (!i_rst48_n)              acc_q         <= '{default: '0};
    else if (state_q == StRun)   acc_q[vidx_q] <= acc_d;
  end

  // Waveform stage (ROM read) and mix stage
  logic             s1_vld_q, s1_en_q, s2_vld_q, s2_en_q;
  logic [1:0]       s1_wave_q;
  logic [OUT_W-1:0] s1_p_q, s2_val_q, wave_val;
  logic [1:0]       quad;
  logic [SINE_AW-1:0] rom_addr;
  logic [OUT_W-2:0] mag;

  always_comb begin
    quad     = s1_p_q[OUT_W-1 -: 2];
    // Quadrants 1 and 3 walk the quarter table backwards.
    rom_addr = s1_p_q[OUT_W-3 -: SINE_AW] ^ {SINE_AW{quad[0]}};
    mag      = rom[rom_addr];
    case (s1_wave_q)
      2'd0:    wave_val = s1_p_q;
      2'd1:    wave_val = {OUT_W{s1_p_q[OUT_W-1]}};
      2'd2:    wave_val = s1_p_q[OUT_W-1] ? {~s1_p_q[OUT_W-2:0], 1'b1}
                                          : {s1_p_q[OUT_W-2:0], 1'b0};
      default: wave_val = quad[1] ? HALF - OUT_W'(mag) : HALF + OUT_W'(mag);
    endcase
  end

  always_ff @(posedge i_clk48) begin
    if (!i_rst48_n) begin
      s1_vld_q  <= 1'b0;
      s1_en_q   <= 1'b0;
      s1_wave_q <= '0;
      s1_p_q    <= '0;
      s2_vld_q  <= 1'b0;
      s2_en_q   <= 1'b0;
      s2_val_q  <= '0;
    end else begin
      s1_vld_q  <= (state_q == StRun);
      s1_en_q   <= f_en_q[vidx_q];
      s1_wave_q <= f_wave_q[vidx_q];
      s1_p_q    <= cur_p;
      s2_vld_q  <= s1_vld_q;
      s2_en_q   <= s1_en_q;
      s2_val_q  <= wave_val;
    end
  end

  logic signed [OUT_W-1:0] s2_sv;
  logic signed [SUM_W-1:0] sum_q, sum_d, contrib;
  logic [OUT_W-1:0]        mix_out;

  always_comb begin
    s2_sv   = {~s2_val_q[OUT_W-1], s2_val_q[OUT_W-2:0]};
    contrib = (s2_vld_q && s2_en_q) ? SUM_W'(s2_sv) : '0;
    sum_d   = sum_q + contrib;
    // Average of VOICES samples: cannot overflow OUT_W.
    mix_out = OUT_W'(sum_d >>> LOG_V);
  end

  // Frame sequencer; the last voice is folded in on the final drain cycle.
  logic [OUT_W-1:0] o_sample_q;
  logic             o_pulse_q;

  always_ff @(posedge i_clk48) begin
    if (!i_rst48_n) begin
      state_q    <= StIdle;
      vidx_q     <= '0;
      drain_q    <= 1'b0;
      sum_q      <= '0;
      o_sample_q <= '0;
      o_pulse_q  <= 1'b0;
    end else begin
      o_pulse_q <= 1'b0;
      sum_q     <= (state_q == StIdle) ? '0 : sum_d;
      unique case (state_q)
        StIdle: begin
          vidx_q <= '0;
          if (strobe) state_q <= StRun;
        end
        StRun: begin
          vidx_q <= vidx_q + VW'(1);
          if (vidx_q == VW'(VOICES - 1)) begin
            state_q <= StDrain;
            drain_q <= 1'b0;
          end
        end
        StDrain: begin
          drain_q <= 1'b1;
          if (drain_q) begin
            state_q    <= StOut;
            o_sample_q <= mix_out;
            o_pulse_q  <= 1'b1;
          end
        end
        StOut:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_sample = o_sample_q;
  assign o_pulse  = o_pulse_q;

endmodule
